// File: rtl/stopwatch_ctrl_if.sv
// Stopwatch controller bus: debounced buttons, tick, counter value in;
// run/clear/direction controls, display value and done pulse out.
interface stopwatch_ctrl_if #(
    parameter int CW = 14
);
    logic          btn_R;
    logic          btn_L;
    logic          btn_U;
    logic          tick;
    logic [CW-1:0] count;
    logic          run_stop;
    logic          clear;
    logic          rev;
    logic          lap_hold;
    logic [CW-1:0] disp_count;
    logic          done;

    // Driver side: buttons, tick generator and counter
    modport master (
        output btn_R, btn_L, btn_U, tick, count,
        input  run_stop, clear, rev, lap_hold, disp_count, done
    );

    // Controller side
    modport slave (
        input  btn_R, btn_L, btn_U, tick, count,
        output run_stop, clear, rev, lap_hold, disp_count, done
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: run/stop/clear FSM, lap freeze of the display,
// count direction and countdown auto-stop with a one-cycle done pulse.
module stopwatch_ctrl #(
    parameter int MAX_COUNT = 10000,
    parameter int CW        = $clog2(MAX_COUNT)
) (
    input  logic           clk,
    input  logic           reset,
    stopwatch_ctrl_if.slave sw
);

    typedef enum logic [1:0] {
        STOP = 2'd0,
        RUN  = 2'd1,
        CLR  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic          rev_q;
    logic          lap_hold_q;
    logic [CW-1:0] lap_reg;
    logic          done_q;

    logic          lap_act;
    logic          auto_stop;
    logic          enter_clr;

    // Next-state and event decode; all button handling lives here
    always_comb begin
        state_next = state;
        lap_act    = 1'b0;
        auto_stop  = 1'b0;
        enter_clr  = 1'b0;
        unique case (state)
            STOP: begin
                // Clear wins over start when both arrive together
                if (sw.btn_L) begin
                    state_next = CLR;
                    enter_clr  = 1'b1;
                end else if (sw.btn_R) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                // Countdown reaches zero on this edge; a run that started at
                // zero sees count==0 here and is allowed to wrap instead
                auto_stop = sw.rev && sw.tick && (sw.count == CW'(1));
                lap_act   = sw.btn_L && !sw.btn_R;
                if (sw.btn_R || auto_stop) begin
                    state_next = STOP;
                end
            end
            CLR: begin
                state_next = STOP;
            end
            default: begin
                state_next = STOP;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= STOP;
        end else begin
            state <= state_next;
        end
    end

    // Lap capture/release; entering clear wipes the frozen value
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lap_hold_q <= 1'b0;
            lap_reg    <= '0;
        end else if (enter_clr) begin
            lap_hold_q <= 1'b0;
            lap_reg    <= '0;
        end else if (lap_act) begin
            if (!lap_hold_q) begin
                lap_reg    <= sw.count;
                lap_hold_q <= 1'b1;
            end else begin
                lap_hold_q <= 1'b0;
            end
        end
    end

    // Direction toggles only while stopped
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rev_q <= 1'b0;
        end else if (state == STOP && sw.btn_U) begin
            rev_q <= ~rev_q;
        end
    end

    // Done pulses for the single cycle following a countdown auto-stop
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            done_q <= 1'b0;
        end else begin
            done_q <= auto_stop;
        end
    end

    assign sw.run_stop   = (state == RUN);
    assign sw.clear      = (state == CLR);
    assign sw.rev        = rev_q;
    assign sw.lap_hold   = lap_hold_q;
    assign sw.done       = done_q;
    assign sw.disp_count = lap_hold_q ? lap_reg : sw.count;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl: a table of per-cycle stimulus and
// expected outputs, plus hand sequences for asynchronous reset cases.
module tb_stopwatch_ctrl;

    localparam int CW = 14;

    logic clk;
    logic reset;

    stopwatch_ctrl_if #(.CW(CW)) sw ();

    stopwatch_ctrl #(.MAX_COUNT(10000), .CW(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .sw    (sw.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          r, l, u, tk;
        logic [CW-1:0] cnt;
        logic          run, clr, rev, lap;
        logic [CW-1:0] disp;
        logic          done;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec %0d: got %0d expected %0d", nm, idx, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic l, input logic u, input logic tk, input int cnt,
                       input logic run, input logic clr, input logic rev, input logic lap,
                       input int disp, input logic done);
        vec_t v;
        v.r = r; v.l = l; v.u = u; v.tk = tk; v.cnt = CW'(cnt);
        v.run = run; v.clr = clr; v.rev = rev; v.lap = lap; v.disp = CW'(disp); v.done = done;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic r, input logic l, input logic u, input logic tk, input int cnt);
        sw.btn_R = r; sw.btn_L = l; sw.btn_U = u; sw.tick = tk; sw.count = CW'(cnt);
    endtask

    task automatic chk_all(input int idx, input logic run, input logic clr, input logic rev,
                           input logic lap, input int disp, input logic done);
        chk("run_stop",   idx, 32'(sw.run_stop),   32'(run));
        chk("clear",      idx, 32'(sw.clear),      32'(clr));
        chk("rev",        idx, 32'(sw.rev),        32'(rev));
        chk("lap_hold",   idx, 32'(sw.lap_hold),   32'(lap));
        chk("disp_count", idx, 32'(sw.disp_count), 32'(disp));
        chk("done",       idx, 32'(sw.done),       32'(done));
    endtask

    initial begin
        //  R  L  U  tk cnt  | run clr rev lap disp done
        // start, five ticks, stop; clear never asserted
        add(1, 0, 0, 0, 0,    1, 0, 0, 0, 0,    0);
        add(0, 0, 0, 1, 0,    1, 0, 0, 0, 0,    0);
        add(0, 0, 0, 1, 1,    1, 0, 0, 0, 1,    0);
        add(0, 0, 0, 1, 2,    1, 0, 0, 0, 2,    0);
        add(0, 0, 0, 1, 3,    1, 0, 0, 0, 3,    0);
        add(0, 0, 0, 1, 4,    1, 0, 0, 0, 4,    0);
        add(1, 0, 0, 0, 5,    0, 0, 0, 0, 5,    0);
        // L+R while stopped: one-cycle clear, buttons in CLR ignored
        add(1, 1, 0, 0, 5,    0, 1, 0, 0, 5,    0);
        add(1, 0, 0, 0, 0,    0, 0, 0, 0, 0,    0);
        add(0, 0, 0, 0, 0,    0, 0, 0, 0, 0,    0);
        // lap capture at 42, frozen while count advances, release at 50
        add(1, 0, 0, 0, 40,   1, 0, 0, 0, 40,   0);
        add(0, 0, 0, 1, 41,   1, 0, 0, 0, 41,   0);
        add(0, 1, 0, 0, 42,   1, 0, 0, 1, 42,   0);
        add(0, 0, 0, 1, 45,   1, 0, 0, 1, 42,   0);
        add(0, 0, 0, 1, 50,   1, 0, 0, 1, 42,   0);
        add(0, 1, 0, 0, 50,   1, 0, 0, 0, 50,   0);
        add(0, 0, 0, 1, 51,   1, 0, 0, 0, 51,   0);
        // lap held across stop, then clear wipes it
        add(0, 1, 0, 0, 51,   1, 0, 0, 1, 51,   0);
        add(0, 0, 0, 1, 60,   1, 0, 0, 1, 51,   0);
        add(1, 0, 0, 0, 60,   0, 0, 0, 1, 51,   0);
        add(0, 0, 0, 0, 60,   0, 0, 0, 1, 51,   0);
        add(0, 1, 0, 0, 60,   0, 1, 0, 0, 60,   0);
        add(0, 0, 0, 0, 0,    0, 0, 0, 0, 0,    0);
        // direction: toggles in STOP only; countdown auto-stop from 3
        add(0, 0, 1, 0, 0,    0, 0, 1, 0, 0,    0);
        add(1, 0, 0, 0, 3,    1, 0, 1, 0, 3,    0);
        add(0, 0, 1, 0, 3,    1, 0, 1, 0, 3,    0);
        add(0, 0, 0, 1, 3,    1, 0, 1, 0, 3,    0);
        add(0, 0, 0, 1, 2,    1, 0, 1, 0, 2,    0);
        add(0, 0, 0, 1, 1,    0, 0, 1, 0, 1,    1);
        add(0, 0, 0, 0, 0,    0, 0, 1, 0, 0,    0);
        // btn_U during CLR ignored, rev survives clear
        add(0, 1, 0, 0, 0,    0, 1, 1, 0, 0,    0);
        add(0, 0, 1, 0, 0,    0, 0, 1, 0, 0,    0);
        // countdown started at zero: wraps, no auto-stop
        add(1, 0, 0, 0, 0,    1, 0, 1, 0, 0,    0);
        add(0, 0, 0, 1, 0,    1, 0, 1, 0, 0,    0);
        add(0, 0, 0, 1, 9999, 1, 0, 1, 0, 9999, 0);
        add(0, 0, 0, 1, 9998, 1, 0, 1, 0, 9998, 0);
        // auto-stop with coincident lap capture
        add(0, 0, 0, 1, 2,    1, 0, 1, 0, 2,    0);
        add(0, 1, 0, 1, 1,    0, 0, 1, 1, 1,    1);
        add(0, 0, 0, 0, 0,    0, 0, 1, 1, 1,    0);
        // auto-stop with coincident btn_R still stops and pulses done
        add(1, 0, 0, 0, 5,    1, 0, 1, 1, 1,    0);
        add(0, 1, 0, 0, 5,    1, 0, 1, 0, 5,    0);
        add(1, 0, 0, 1, 1,    0, 0, 1, 0, 1,    1);
        add(0, 0, 0, 0, 0,    0, 0, 1, 0, 0,    0);
        // up count: wrap and count==1 never stop or pulse done
        add(0, 0, 1, 0, 0,    0, 0, 0, 0, 0,    0);
        add(1, 0, 0, 0, 9999, 1, 0, 0, 0, 9999, 0);
        add(0, 0, 0, 1, 9999, 1, 0, 0, 0, 9999, 0);
        add(0, 0, 0, 1, 0,    1, 0, 0, 0, 0,    0);
        add(0, 0, 0, 1, 1,    1, 0, 0, 0, 1,    0);
        // set up RUN with rev=1 and a held lap for the reset case
        add(1, 0, 0, 0, 0,    0, 0, 0, 0, 0,    0);
        add(0, 0, 1, 0, 0,    0, 0, 1, 0, 0,    0);
        add(1, 0, 0, 0, 20,   1, 0, 1, 0, 20,   0);
        add(0, 1, 0, 0, 20,   1, 0, 1, 1, 20,   0);

        // reset held with a button pressed: nothing latched
        reset = 1'b0;
        drive(1, 0, 0, 0, 0);
        #12;
        chk_all(-1, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        drive(0, 0, 0, 0, 0);
        @(posedge clk); #1;
        chk_all(-2, 0, 0, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].r, vecs[i].l, vecs[i].u, vecs[i].tk, int'(vecs[i].cnt));
            @(posedge clk); #1;
            chk_all(i, vecs[i].run, vecs[i].clr, vecs[i].rev, vecs[i].lap,
                    int'(vecs[i].disp), vecs[i].done);
        end

        // asynchronous reset mid-RUN with lap held and rev=1
        @(negedge clk);
        drive(0, 0, 0, 0, 77);
        #1;
        chk("pre_reset_disp", 100, 32'(sw.disp_count), 32'd20);
        #1 reset = 1'b0;
        #1;
        chk_all(101, 0, 0, 0, 0, 77, 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        chk_all(102, 0, 0, 0, 0, 77, 0);

        // asynchronous reset mid-CLR
        @(negedge clk);
        drive(0, 1, 0, 0, 9);
        @(posedge clk); #1;
        chk("clr_before_reset", 103, 32'(sw.clear), 32'd1);
        drive(0, 0, 0, 0, 9);
        #1 reset = 1'b0;
        #1;
        chk_all(104, 0, 0, 0, 0, 9, 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        chk_all(105, 0, 0, 0, 0, 9, 0);
        // back in STOP, a start pulse runs
        @(negedge clk);
        drive(1, 0, 0, 0, 9);
        @(posedge clk); #1;
        chk_all(106, 1, 0, 0, 0, 9, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 SHALL have parameter MAX_COUNT, default 10000, meaning the counter modulus; valid counts are 0..MAX_COUNT-1.
REQ-002 SHALL have parameter CW, default $clog2(MAX_COUNT) (=14), meaning the count width.
REQ-003 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port btn_R  input  1  debounced one-cycle pulse requesting run/stop toggle.
REQ-006 SHALL have port btn_L  input  1  debounced one-cycle pulse requesting clear (stopped) or lap (running).
REQ-007 SHALL have port btn_U  input  1  debounced one-cycle pulse requesting direction toggle.
REQ-008 SHALL have port tick  input  1  one-cycle count-enable pulse from the tick generator.
REQ-009 SHALL have port count  input  CW  current counter value.
REQ-010 SHALL have port run_stop  output  1  high while counting is enabled; gates the tick generator.
REQ-011 SHALL have port clear  output  1  one-cycle pulse zeroing the counter and tick generator.
REQ-012 SHALL have port rev  output  1  count direction; 0 = up, 1 = down.
REQ-013 SHALL have port lap_hold  output  1  high while the display is frozen on a lap value.
REQ-014 SHALL have port disp_count  output  CW  value to the FND controller.
REQ-015 SHALL have port done  output  1  one-cycle pulse on countdown auto-stop.

Function
REQ-016 SHALL implement a Moore FSM with states STOP, RUN, CLR; run_stop = (state==RUN), clear = (state==CLR), both registered-state decodes.
REQ-017 STOP: btn_L -> CLR; else btn_R -> RUN; btn_L and btn_R in the same cycle -> CLR only (btn_R dropped).
REQ-018 CLR: unconditionally -> STOP after exactly one cycle; all button pulses during CLR ignored.
REQ-019 RUN: btn_R -> STOP; btn_L with no btn_R -> lap action (REQ-021/022), state stays RUN; btn_L with btn_R -> STOP, btn_L dropped.
REQ-020 Latency: a button pulse in cycle N changes run_stop/clear in cycle N+1.
REQ-021 Lap capture: btn_L in RUN with lap_hold=0 SHALL register lap_reg <= count and set lap_hold=1 on the same edge.
REQ-022 Lap release: btn_L in RUN with lap_hold=1 SHALL clear lap_hold; lap_reg retains its value.
REQ-023 Transition RUN->STOP SHALL leave lap_hold and lap_reg unchanged; entering CLR SHALL zero lap_reg and lap_hold.
REQ-024 disp_count SHALL be combinational: lap_hold ? lap_reg : count.
REQ-025 rev SHALL toggle on btn_U only in STOP; btn_U in RUN or CLR SHALL be ignored; rev is not changed by CLR.
REQ-026 Countdown auto-stop: in RUN with rev=1, tick=1 and count==1 (counter reaches 0 on this edge), next state SHALL be STOP and done SHALL pulse high for exactly that next cycle.
REQ-027 Auto-stop coincident with btn_R: next state STOP, done SHALL still pulse; coincident btn_L lap action SHALL still apply.
REQ-028 In RUN with rev=1 and count==0 on entry (started at zero), no auto-stop; counter wrap to MAX_COUNT-1 is permitted.
REQ-029 Up-count wrap at MAX_COUNT-1 SHALL NOT affect controller state; done SHALL stay 0 when rev=0.
REQ-030 tick SHALL be ignored outside RUN; count is treated as unsigned CW-bit.

Reset
REQ-031 reset=0 SHALL asynchronously force state=STOP, run_stop=0, clear=0, rev=0, lap_hold=0, lap_reg=0, done=0.
REQ-032 Reset asserted mid-RUN or mid-CLR SHALL abort immediately; after release the block SHALL be in STOP, awaiting btn_R.
REQ-033 Outputs SHALL be valid from the first rising clk edge after reset deasserts; no button pulse is latched across reset.

Verification
REQ-034 Reset, btn_R pulse, 5 ticks, btn_R -> run_stop 0->1 one cycle after first pulse, 1->0 after second; clear never asserted.
REQ-035 Stopped, btn_L and btn_R same cycle -> clear=1 for exactly one cycle, run_stop stays 0, state returns to STOP.
REQ-036 RUN with count=42, btn_L -> lap_hold=1, disp_count=42 while count advances to 50; second btn_L -> disp_count follows count=50; btn_R then btn_L -> lap_reg=0, lap_hold=0.
REQ-037 btn_U in STOP -> rev=1; btn_U in RUN -> rev unchanged; btn_R start at count=3, ticks -> done=1 one cycle after tick at count=1, run_stop=0, count held at 0.
REQ-038 rev=1, start at count=0 -> no done, run_stop stays 1 through counter wrap to 9999.
REQ-039 Assert reset mid-RUN with lap_hold=1, rev=1 -> all outputs immediately 0 asynchronously, disp_count equals count.
